// File: rtl/stim_driver.sv
// stim_driver: walks a shift-register DUT through a fixed sequence of
// operating-mode phases (load/shift/rotate/hold/disable) for a programmed
// number of rounds, with pseudo-random data from an 8-bit Fibonacci LFSR.
// All outputs come straight from flops; they are computed from the
// next-state values so that they line up with the state register.
module stim_driver #(
   parameter int         PHASE_LEN = 8,
   parameter int         ROUNDS    = 4,
   parameter logic [7:0] SEED      = 8'hA5
) (
   input  logic       CLK,
   input  logic       RESET_L,
   input  logic       START,
   output logic       ENB,
   output logic       DIR,
   output logic [1:0] MODO,
   output logic       S_IN,
   output logic [3:0] D,
   output logic [2:0] PHASE,
   output logic [7:0] ROUND,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_SHL  = 4'd2,
      S_SHR  = 4'd3,
      S_ROTL = 4'd4,
      S_ROTR = 4'd5,
      S_HOLD = 4'd6,
      S_DIS  = 4'd7,
      S_DONE = 4'd8
   } state_t;

   localparam logic [7:0] LAST_CNT   = 8'(PHASE_LEN - 1);
   localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

   state_t     state, state_nxt;
   state_t     after_load, after_load_nxt;   // phase entered when LOAD ends
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] lfsr, lfsr_nxt, lfsr_step;
   logic [7:0] round, round_nxt;

   logic       enb_nxt, dir_nxt, s_in_nxt, busy_nxt, done_nxt;
   logic [1:0] modo_nxt;
   logic [3:0] d_nxt;
   logic [2:0] phase_nxt;

   // x^8+x^6+x^5+x^4+1, shifting towards the MSB
   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign ROUND     = round;

   // Next-state: phase sequencing, cycle counting, round counting, LFSR stepping
   always_comb begin
      state_nxt      = state;
      after_load_nxt = after_load;
      cnt_nxt        = cnt;
      lfsr_nxt       = lfsr;
      round_nxt      = round;
      case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_nxt      = S_LOAD;
               after_load_nxt = S_SHL;
               cnt_nxt        = '0;
               lfsr_nxt       = SEED;
               round_nxt      = '0;
            end
         end
         S_LOAD: begin
            state_nxt = after_load;
            cnt_nxt   = '0;
            lfsr_nxt  = lfsr_step;
         end
         default: begin
            lfsr_nxt = lfsr_step;
            if (cnt == LAST_CNT) begin
               cnt_nxt   = '0;
               state_nxt = S_LOAD;
               case (state)
                  S_SHL:   after_load_nxt = S_SHR;
                  S_SHR:   after_load_nxt = S_ROTL;
                  S_ROTL:  after_load_nxt = S_ROTR;
                  S_ROTR:  after_load_nxt = S_HOLD;
                  S_HOLD:  after_load_nxt = S_DIS;
                  default: begin
                     // end of DIS closes the round
                     if (round == LAST_ROUND) begin
                        state_nxt = S_DONE;
                     end else begin
                        round_nxt      = round + 8'd1;
                        after_load_nxt = S_SHL;
                     end
                  end
               endcase
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
      endcase
   end

   // Output decode for the state about to be entered, using the LFSR value it will hold
   always_comb begin
      enb_nxt   = 1'b0;
      dir_nxt   = 1'b0;
      modo_nxt  = 2'b00;
      s_in_nxt  = 1'b0;
      d_nxt     = 4'h0;
      phase_nxt = 3'd0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      case (state_nxt)
         S_LOAD: begin
            enb_nxt   = 1'b1;
            modo_nxt  = 2'b10;
            d_nxt     = lfsr_nxt[3:0];
            phase_nxt = 3'd1;
         end
         S_SHL: begin
            enb_nxt   = 1'b1;
            s_in_nxt  = lfsr_nxt[0];
            phase_nxt = 3'd2;
         end
         S_SHR: begin
            enb_nxt   = 1'b1;
            dir_nxt   = 1'b1;
            s_in_nxt  = lfsr_nxt[0];
            phase_nxt = 3'd3;
         end
         S_ROTL: begin
            enb_nxt   = 1'b1;
            modo_nxt  = 2'b01;
            phase_nxt = 3'd4;
         end
         S_ROTR: begin
            enb_nxt   = 1'b1;
            dir_nxt   = 1'b1;
            modo_nxt  = 2'b01;
            phase_nxt = 3'd5;
         end
         S_HOLD: begin
            enb_nxt   = 1'b1;
            modo_nxt  = 2'b11;
            s_in_nxt  = lfsr_nxt[0];
            phase_nxt = 3'd6;
         end
         S_DIS: begin
            s_in_nxt  = lfsr_nxt[0];
            phase_nxt = 3'd7;
         end
         S_DONE: begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
         end
         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   // State, counters, LFSR and registered outputs
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state      <= S_IDLE;
         after_load <= S_SHL;
         cnt        <= '0;
         lfsr       <= SEED;
         round      <= '0;
         ENB        <= 1'b0;
         DIR        <= 1'b0;
         MODO       <= 2'b00;
         S_IN       <= 1'b0;
         D          <= 4'h0;
         PHASE      <= 3'd0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         state      <= state_nxt;
         after_load <= after_load_nxt;
         cnt        <= cnt_nxt;
         lfsr       <= lfsr_nxt;
         round      <= round_nxt;
         ENB        <= enb_nxt;
         DIR        <= dir_nxt;
         MODO       <= modo_nxt;
         S_IN       <= s_in_nxt;
         D          <= d_nxt;
         PHASE      <= phase_nxt;
         BUSY       <= busy_nxt;
         DONE       <= done_nxt;
      end
   end

endmodule
